axi_stream_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one AXI-Stream sink among `NumInputs` requesters, e.g. the 32→8 bit `axi_stream_dw_downsizer` serialising traffic from several producers.
- Grants one input at a time and holds the grant until the `tlast` beat of that packet has been handshaked on the output, so packets are never interleaved.
- Rotates priority after every packet.
- Exposes the current grant and a per-packet beat count for debug.

---
 rtl/axi_stream_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_axi_stream_rr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream sink among NumInputs producers.
// A grant is held from the first beat until the tlast handshake, so packets never interleave.
module axi_stream_rr_arbiter #(
  parameter int NumInputs = 4,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 0,
  parameter int DestWidth = 0,
  parameter int UserWidth = 0,
  parameter int CntWidth  = 16,
  localparam int SelW  = $clog2(NumInputs),
  localparam int IdW   = (IdWidth   > 0) ? IdWidth   : 1,
  localparam int DestW = (DestWidth > 0) ? DestWidth : 1,
  localparam int UserW = (UserWidth > 0) ? UserWidth : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumInputs-1:0][DataWidth-1:0]   in_tdata_i,
  input  logic [NumInputs-1:0][DataWidth/8-1:0] in_tstrb_i,
  input  logic [NumInputs-1:0][DataWidth/8-1:0] in_tkeep_i,
  input  logic [NumInputs-1:0]                  in_tlast_i,
  input  logic [NumInputs-1:0][IdW-1:0]         in_tid_i,
  input  logic [NumInputs-1:0][DestW-1:0]       in_tdest_i,
  input  logic [NumInputs-1:0][UserW-1:0]       in_tuser_i,
  input  logic [NumInputs-1:0]                  in_tvalid_i,
  output logic [NumInputs-1:0]                  in_tready_o,
  output logic [DataWidth-1:0]                  out_tdata_o,
  output logic [DataWidth/8-1:0]                out_tstrb_o,
  output logic [DataWidth/8-1:0]                out_tkeep_o,
  output logic                                  out_tlast_o,
  output logic [IdW-1:0]                        out_tid_o,
  output logic [DestW-1:0]                      out_tdest_o,
  output logic [UserW-1:0]                      out_tuser_o,
  output logic                                  out_tvalid_o,
  input  logic                                  out_tready_i,
  output logic [SelW-1:0]                       sel_o,
  output logic                                  busy_o,
  output logic [CntWidth-1:0]                   beat_cnt_o
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t              r_state, w_state_nxt;
  logic [SelW-1:0]     r_sel, w_sel_nxt;
  logic [SelW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [CntWidth-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [SelW-1:0]     w_pick;
  logic [SelW-1:0]     w_sel_inc;
  logic                w_any_valid;
  logic                w_hs;

  // Explicit modulo so non-power-of-two input counts wrap correctly.
  function automatic logic [SelW-1:0] wrap_add(input logic [SelW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NumInputs) sum = sum - NumInputs;
    return SelW'(sum);
  endfunction

  // First valid input at or above rr_ptr, wrapping past NumInputs-1 back to 0.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that leaves one
    // unassigned would infer a latch.
    w_pick      = r_rr_ptr;
    w_any_valid = 1'b0;
    for (int i = 0; i < NumInputs; i++) begin
      if (!w_any_valid && in_tvalid_i[wrap_add(r_rr_ptr, i)]) begin
        w_any_valid = 1'b1;
        w_pick      = wrap_add(r_rr_ptr, i);
      end
    end
  end

  assign w_sel_inc = (r_sel == SelW'(NumInputs - 1)) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    in_tready_o    = '0;
    out_tvalid_o   = 1'b0;
    w_hs           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt    = ST_LOCKED;
          w_sel_nxt      = w_pick;
          w_beat_cnt_nxt = '0;
        end
      end
      ST_LOCKED: begin
        out_tvalid_o       = in_tvalid_i[r_sel];
        in_tready_o[r_sel] = out_tready_i;
        w_hs               = out_tvalid_o & out_tready_i;
        if (w_hs) begin
          if (r_beat_cnt != '1) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (in_tlast_i[r_sel]) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = w_sel_inc;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Data path is a pure mux on the registered grant; absent sideband fields read as 0.
  assign out_tdata_o = in_tdata_i[r_sel];
  assign out_tstrb_o = in_tstrb_i[r_sel];
  assign out_tkeep_o = in_tkeep_i[r_sel];
  assign out_tlast_o = in_tlast_i[r_sel];
  assign out_tid_o   = (IdWidth   > 0) ? in_tid_i[r_sel]   : '0;
  assign out_tdest_o = (DestWidth > 0) ? in_tdest_i[r_sel] : '0;
  assign out_tuser_o = (UserWidth > 0) ? in_tuser_i[r_sel] : '0;

  assign sel_o      = r_sel;
  assign busy_o     = (r_state == ST_LOCKED);
  assign beat_cnt_o = r_beat_cnt;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Directed bench for axi_stream_rr_arbiter: cycle table for arbitration order, plus
// hand sequences for downsizer backpressure and asynchronous reset mid-packet.
module tb_axi_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [N-1:0][DW-1:0]    in_tdata_i;
  logic [N-1:0][DW/8-1:0]  in_tstrb_i, in_tkeep_i;
  logic [N-1:0]            in_tlast_i;
  logic [N-1:0][0:0]       in_tid_i, in_tdest_i, in_tuser_i;
  logic [N-1:0]            in_tvalid_i;
  logic [N-1:0]            in_tready_o;
  logic [DW-1:0]           out_tdata_o;
  logic [DW/8-1:0]         out_tstrb_o, out_tkeep_o;
  logic                    out_tlast_o;
  logic [0:0]              out_tid_o, out_tdest_o, out_tuser_o;
  logic                    out_tvalid_o;
  logic                    out_tready_i;
  logic [1:0]              sel_o;
  logic                    busy_o;
  logic [15:0]             beat_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  axi_stream_rr_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_tdata_i(in_tdata_i), .in_tstrb_i(in_tstrb_i), .in_tkeep_i(in_tkeep_i),
    .in_tlast_i(in_tlast_i), .in_tid_i(in_tid_i), .in_tdest_i(in_tdest_i),
    .in_tuser_i(in_tuser_i), .in_tvalid_i(in_tvalid_i), .in_tready_o(in_tready_o),
    .out_tdata_o(out_tdata_o), .out_tstrb_o(out_tstrb_o), .out_tkeep_o(out_tkeep_o),
    .out_tlast_o(out_tlast_o), .out_tid_o(out_tid_o), .out_tdest_o(out_tdest_o),
    .out_tuser_o(out_tuser_o), .out_tvalid_o(out_tvalid_o), .out_tready_i(out_tready_i),
    .sel_o(sel_o), .busy_o(busy_o), .beat_cnt_o(beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One row per clock cycle: inputs driven after the edge, outputs checked at negedge.
  typedef struct {
    logic [3:0]  v;      // per-input tvalid
    logic [3:0]  l;      // per-input tlast
    logic        rdy;    // out_tready_i
    logic [3:0]  b;      // beat index placed in every input's tdata[3:0]
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic        e_ol;
    logic [1:0]  e_sel;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic rdy, logic [3:0] b,
                              logic [3:0] e_rdy, logic e_ov, logic e_ol, logic [1:0] e_sel,
                              logic e_busy, logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.l = l; r.rdy = rdy; r.b = b;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_ol = e_ol; r.e_sel = e_sel;
    r.e_busy = e_busy; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Input i carries data {i, b} so the forwarded word names its source and beat.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                       input logic [3:0] b);
    in_tvalid_i  = v;
    in_tlast_i   = l;
    out_tready_i = rdy;
    for (int i = 0; i < N; i++) in_tdata_i[i] = {24'h0, 4'(i), b};
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_row(input vec_t r, input int n);
    check($sformatf("row%0d_in_tready", n), 32'(in_tready_o), 32'(r.e_rdy));
    check($sformatf("row%0d_out_tvalid", n), 32'(out_tvalid_o), 32'(r.e_ov));
    if (r.e_ov) begin
      check($sformatf("row%0d_out_tdata", n), out_tdata_o, {24'h0, 2'b00, r.e_sel, r.b});
      check($sformatf("row%0d_out_tlast", n), 32'(out_tlast_o), 32'(r.e_ol));
    end
    check($sformatf("row%0d_sel", n), 32'(sel_o), 32'(r.e_sel));
    check($sformatf("row%0d_busy", n), 32'(busy_o), 32'(r.e_busy));
    check($sformatf("row%0d_beat_cnt", n), 32'(beat_cnt_o), 32'(r.e_cnt));
  endtask

  logic [31:0] cap;
  logic [7:0]  exp_bytes [4];
  logic [1:0]  exp_src   [2];
  int          waited;

  initial begin
    // Round-robin: all four inputs, two-beat packets, one IDLE cycle between packets.
    vecs.push_back(mk(4'hF, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'hF, 4'h0, 1, 0, 4'h1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(4'hF, 4'h1, 1, 1, 4'h1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(4'hE, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(4'hE, 4'h0, 1, 0, 4'h2, 1, 0, 1, 1, 0));
    vecs.push_back(mk(4'hE, 4'h2, 1, 1, 4'h2, 1, 1, 1, 1, 1));
    vecs.push_back(mk(4'hC, 4'h0, 1, 0, 4'h0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(4'hC, 4'h0, 1, 0, 4'h4, 1, 0, 2, 1, 0));
    vecs.push_back(mk(4'hC, 4'h4, 1, 1, 4'h4, 1, 1, 2, 1, 1));
    vecs.push_back(mk(4'h8, 4'h0, 1, 0, 4'h0, 0, 0, 2, 0, 2));
    vecs.push_back(mk(4'h8, 4'h0, 1, 0, 4'h8, 1, 0, 3, 1, 0));
    vecs.push_back(mk(4'h8, 4'h8, 1, 1, 4'h8, 1, 1, 3, 1, 1));
    vecs.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 3, 0, 2));
    // No interleave: input 1 stalls 3 cycles after beat 2 while input 2 keeps requesting.
    vecs.push_back(mk(4'h6, 4'h0, 1, 0, 4'h0, 0, 0, 3, 0, 2));
    vecs.push_back(mk(4'h6, 4'h0, 1, 0, 4'h2, 1, 0, 1, 1, 0));
    vecs.push_back(mk(4'h6, 4'h0, 1, 1, 4'h2, 1, 0, 1, 1, 1));
    vecs.push_back(mk(4'h4, 4'h0, 1, 2, 4'h2, 0, 0, 1, 1, 2));
    vecs.push_back(mk(4'h4, 4'h0, 1, 2, 4'h2, 0, 0, 1, 1, 2));
    vecs.push_back(mk(4'h4, 4'h0, 1, 2, 4'h2, 0, 0, 1, 1, 2));
    vecs.push_back(mk(4'h6, 4'h0, 1, 2, 4'h2, 1, 0, 1, 1, 2));
    vecs.push_back(mk(4'h6, 4'h2, 1, 3, 4'h2, 1, 1, 1, 1, 3));
    vecs.push_back(mk(4'h4, 4'h0, 1, 0, 4'h0, 0, 0, 1, 0, 4));
    vecs.push_back(mk(4'h4, 4'h4, 1, 0, 4'h4, 1, 1, 2, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 2, 0, 1));
    // Wrap-around and single-beat packets, with one backpressured cycle.
    vecs.push_back(mk(4'h8, 4'h8, 1, 0, 4'h0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(4'h8, 4'h8, 1, 0, 4'h8, 1, 1, 3, 1, 0));
    vecs.push_back(mk(4'h9, 4'h9, 1, 0, 4'h0, 0, 0, 3, 0, 1));
    vecs.push_back(mk(4'h9, 4'h9, 0, 0, 4'h0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h9, 4'h9, 1, 0, 4'h1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4'h8, 4'h8, 1, 0, 4'h0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'h8, 4'h8, 1, 0, 4'h8, 1, 1, 3, 1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 3, 0, 1));

    in_tstrb_i = '1;
    in_tkeep_i = '1;
    in_tid_i   = '0;
    in_tdest_i = '0;
    in_tuser_i = '0;

    // Reset held 5 cycles with every input requesting.
    rst_i = 1'b1;
    drive(4'hF, 4'h0, 1'b1, 4'h0);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_in_tready", 32'(in_tready_o), 32'h0);
    check("reset_out_tvalid", 32'(out_tvalid_o), 32'h0);
    check("reset_sel", 32'(sel_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_beat_cnt", 32'(beat_cnt_o), 32'h0);
    next_cycle();
    rst_i = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].l, vecs[k].rdy, vecs[k].b);
      @(negedge clk_i);
      check_row(vecs[k], k);
      next_cycle();
    end

    // Downsizer backpressure: a 32->8 serialiser holds out_tready low for 4 byte cycles.
    exp_bytes[0] = 8'hef; exp_bytes[1] = 8'h56; exp_bytes[2] = 8'h34; exp_bytes[3] = 8'h12;
    exp_src[0] = 2'd0;    exp_src[1] = 2'd3;
    drive(4'h9, 4'h9, 1'b1, 4'h0);
    in_tdata_i[0] = 32'h1234_56ef;
    in_tdata_i[3] = 32'h1234_56ef;
    for (int p = 0; p < 2; p++) begin
      waited = 0;
      @(negedge clk_i);
      while (!out_tvalid_o && waited < 10) begin
        @(negedge clk_i);
        waited++;
      end
      check($sformatf("ds_pkt%0d_grant_in_time", p), 32'(out_tvalid_o), 32'h1);
      check($sformatf("ds_pkt%0d_src", p), 32'(sel_o), 32'(exp_src[p]));
      check($sformatf("ds_pkt%0d_tlast", p), 32'(out_tlast_o), 32'h1);
      cap = out_tdata_o;
      next_cycle();
      out_tready_i = 1'b0;
      in_tvalid_i[exp_src[p]] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk_i);
        check($sformatf("ds_pkt%0d_byte%0d", p, k), 32'(cap[8*k +: 8]), 32'(exp_bytes[k]));
        check($sformatf("ds_pkt%0d_hold%0d", p, k), 32'(in_tready_o), 32'h0);
        next_cycle();
      end
      out_tready_i = 1'b1;
    end

    // Reset mid-packet: 3-beat packet from input 2, reset after beat 1 has handshaked.
    drive(4'h4, 4'h0, 1'b1, 4'h0);
    next_cycle();
    @(negedge clk_i);
    check("rstmid_granted", 32'(sel_o), 32'h2);
    next_cycle();
    drive(4'h4, 4'h0, 1'b1, 4'h1);
    @(negedge clk_i);
    check("rstmid_cnt_before", 32'(beat_cnt_o), 32'h1);
    check("rstmid_busy_before", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    #1;
    check("rstmid_out_tvalid", 32'(out_tvalid_o), 32'h0);
    check("rstmid_in_tready", 32'(in_tready_o), 32'h0);
    check("rstmid_busy", 32'(busy_o), 32'h0);
    check("rstmid_sel", 32'(sel_o), 32'h0);
    check("rstmid_cnt", 32'(beat_cnt_o), 32'h0);
    next_cycle();
    rst_i = 1'b0;
    drive(4'h4, 4'h0, 1'b1, 4'h0);
    @(negedge clk_i);
    check("rstmid_idle_after", 32'(busy_o), 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("rstmid_regrant_sel", 32'(sel_o), 32'h2);
    check("rstmid_regrant_busy", 32'(busy_o), 32'h1);
    check("rstmid_regrant_cnt", 32'(beat_cnt_o), 32'h0);
    check("rstmid_regrant_ready", 32'(in_tready_o), 32'h4);
    check("rstmid_regrant_data", out_tdata_o, 32'h0000_0020);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
